// File: rtl/rr_index_arbiter.sv
// Round-robin arbiter with ownership lock: grants one requester, reports it as a
// binary index, and holds the grant until the owner releases it or the hold timer expires.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no owner; scanning I_Req from Ptr for the next winner
// ST_GRANT| owner latched in O_Idx; waiting for I_Rls or hold timeout
module rr_index_arbiter #(
   parameter int NUM_ENTRY     = 8,
   parameter int LOG_NUM_ENTRY = 3,
   parameter int MAX_HOLD      = 16,
   parameter int LOG_MAX_HOLD  = 5
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [NUM_ENTRY-1:0]     I_Req,
   input  logic                     I_Rls,
   output logic                     O_Vld,
   output logic [LOG_NUM_ENTRY-1:0] O_Idx,
   output logic                     O_Tout,
   output logic                     O_Busy
);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t                   r_state, w_state_nxt;
   logic [LOG_NUM_ENTRY-1:0] r_ptr, w_ptr_nxt;
   logic [LOG_NUM_ENTRY-1:0] r_idx, w_idx_nxt;
   logic [LOG_MAX_HOLD-1:0]  r_cnt, w_cnt_nxt;
   logic                     r_tout, w_tout_nxt;

   logic                     w_found;
   logic [LOG_NUM_ENTRY-1:0] w_winner;
   logic [LOG_NUM_ENTRY:0]   w_pos;
   logic [LOG_NUM_ENTRY-1:0] w_owner_inc;
   logic                     w_timeout;

   // Circular scan starting at r_ptr; the extra bit of w_pos holds r_ptr+k before the wrap.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      w_pos    = '0;
      for (int k = 0; k < NUM_ENTRY; k++) begin
         w_pos = {1'b0, r_ptr} + (LOG_NUM_ENTRY+1)'(k);
         if (w_pos >= (LOG_NUM_ENTRY+1)'(NUM_ENTRY))
            w_pos = w_pos - (LOG_NUM_ENTRY+1)'(NUM_ENTRY);
         if (!w_found && I_Req[w_pos[LOG_NUM_ENTRY-1:0]]) begin
            w_found  = 1'b1;
            w_winner = w_pos[LOG_NUM_ENTRY-1:0];
         end
      end
   end

   assign w_owner_inc = (r_idx == LOG_NUM_ENTRY'(NUM_ENTRY-1)) ? '0 : r_idx + 1'b1;
   assign w_timeout   = (MAX_HOLD != 0) && (r_cnt == LOG_MAX_HOLD'(MAX_HOLD-1));

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_idx;
      w_cnt_nxt   = r_cnt;
      w_tout_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_found) begin
               w_state_nxt = ST_GRANT;
               w_idx_nxt   = w_winner;
               w_cnt_nxt   = '0;
            end
         end
         ST_GRANT: begin
            // A release in the timeout cycle wins, so no timeout pulse then.
            if (I_Rls) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_owner_inc;
            end else if (w_timeout) begin
               w_state_nxt = ST_IDLE;
               w_ptr_nxt   = w_owner_inc;
               w_tout_nxt  = 1'b1;
            end else if (r_cnt != LOG_MAX_HOLD'(MAX_HOLD)) begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_idx   <= '0;
         r_cnt   <= '0;
         r_tout  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_idx   <= w_idx_nxt;
         r_cnt   <= w_cnt_nxt;
         r_tout  <= w_tout_nxt;
      end
   end

   assign O_Vld  = (r_state == ST_GRANT);
   assign O_Busy = (r_state == ST_GRANT);
   assign O_Idx  = r_idx;
   assign O_Tout = r_tout;

endmodule

// File: tb/tb_rr_index_arbiter.sv
// Bench for rr_index_arbiter: an 8-entry/16-hold instance and a 5-entry/4-hold instance,
// driven by directed scenarios and random traffic, compared against a behavioural model.
module tb_rr_index_arbiter;

   logic       clock;
   logic       reset;
   logic [7:0] req_a;
   logic       rls_a;
   logic       vld_a, tout_a, busy_a;
   logic [2:0] idx_a;
   logic [4:0] req_b;
   logic       rls_b;
   logic       vld_b, tout_b, busy_b;
   logic [2:0] idx_b;

   int n_chk = 0;
   int n_err = 0;

   rr_index_arbiter #(.NUM_ENTRY(8), .LOG_NUM_ENTRY(3), .MAX_HOLD(16), .LOG_MAX_HOLD(5)) u_dut_a (
      .clock(clock), .reset(reset), .I_Req(req_a), .I_Rls(rls_a),
      .O_Vld(vld_a), .O_Idx(idx_a), .O_Tout(tout_a), .O_Busy(busy_a));

   rr_index_arbiter #(.NUM_ENTRY(5), .LOG_NUM_ENTRY(3), .MAX_HOLD(4), .LOG_MAX_HOLD(3)) u_dut_b (
      .clock(clock), .reset(reset), .I_Req(req_b), .I_Rls(rls_b),
      .O_Vld(vld_b), .O_Idx(idx_b), .O_Tout(tout_b), .O_Busy(busy_b));

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   typedef struct {
      bit busy;
      int owner;
      int ptr;
      int age;
      bit tout;
   } mdl_t;

   mdl_t m_a, m_b;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // One clock of arbiter behaviour; age counts cycles the current owner has held the grant.
   function automatic mdl_t mdl_step(mdl_t s, bit rst, bit [7:0] req, bit rls, int n, int mh);
      mdl_t r;
      r = s;
      r.tout = 1'b0;
      if (rst) begin
         r.busy = 1'b0; r.owner = 0; r.ptr = 0; r.age = 0;
      end else if (!s.busy) begin
         for (int k = 0; k < n; k++) begin
            int c;
            c = (s.ptr + k) % n;
            if (((req >> c) & 8'd1) != 8'd0) begin
               r.busy = 1'b1; r.owner = c; r.age = 0;
               break;
            end
         end
      end else if (rls) begin
         r.busy = 1'b0; r.ptr = (s.owner + 1) % n;
      end else if (mh != 0 && s.age == mh - 1) begin
         r.busy = 1'b0; r.ptr = (s.owner + 1) % n; r.tout = 1'b1;
      end else begin
         r.age = s.age + 1;
      end
      return r;
   endfunction

   task automatic step(input bit rst, input bit [7:0] ra, input bit la, input bit [4:0] rb, input bit lb);
      reset = rst; req_a = ra; rls_a = la; req_b = rb; rls_b = lb;
      @(posedge clock);
      m_a = mdl_step(m_a, rst, ra, la, 8, 16);
      m_b = mdl_step(m_b, rst, {3'b000, rb}, lb, 5, 4);
      #1;
      chk("a_vld",  int'(vld_a),  int'(m_a.busy));
      chk("a_busy", int'(busy_a), int'(m_a.busy));
      chk("a_idx",  int'(idx_a),  m_a.owner);
      chk("a_tout", int'(tout_a), int'(m_a.tout));
      chk("b_vld",  int'(vld_b),  int'(m_b.busy));
      chk("b_busy", int'(busy_b), int'(m_b.busy));
      chk("b_idx",  int'(idx_b),  m_b.owner);
      chk("b_tout", int'(tout_b), int'(m_b.tout));
   endtask

   task automatic sa(input bit rst, input bit [7:0] ra, input bit la);
      step(rst, ra, la, 5'd0, 1'b0);
   endtask

   task automatic sb(input bit rst, input bit [4:0] rb, input bit lb);
      step(rst, 8'd0, 1'b0, rb, lb);
   endtask

   initial begin
      m_a = '{busy: 1'b0, owner: 0, ptr: 0, age: 0, tout: 1'b0};
      m_b = m_a;
      reset = 1'b1; req_a = '0; rls_a = 1'b0; req_b = '0; rls_b = 1'b0;

      sa(1, 8'h00, 0);
      sa(1, 8'h00, 0);
      repeat (5) begin
         sa(0, 8'h00, 0);
         chk("idle_vld", int'(vld_a), 0);
         chk("idle_idx", int'(idx_a), 0);
      end

      sa(0, 8'h24, 0);
      chk("grant2_vld", int'(vld_a), 1);
      chk("grant2_idx", int'(idx_a), 2);
      repeat (3) sa(0, 8'h24, 0);
      sa(0, 8'h24, 1);
      chk("rls_vld", int'(vld_a), 0);
      sa(0, 8'h24, 0);
      chk("grant5_idx", int'(idx_a), 5);
      sa(0, 8'h24, 1);

      sa(1, 8'h00, 0);
      for (int k = 0; k < 9; k++) begin
         sa(0, 8'hFF, 0);
         chk("rr_vld", int'(vld_a), 1);
         chk("rr_idx", int'(idx_a), k % 8);
         sa(0, 8'hFF, 1);
         chk("rr_gap", int'(vld_a), 0);
      end

      sa(1, 8'h00, 0);
      sa(0, 8'h40, 0);
      chk("own6_idx", int'(idx_a), 6);
      sa(1, 8'h40, 0);
      chk("rst_vld",  int'(vld_a), 0);
      chk("rst_idx",  int'(idx_a), 0);
      chk("rst_tout", int'(tout_a), 0);
      sa(0, 8'hC0, 0);
      chk("post_rst_idx", int'(idx_a), 6);
      sa(0, 8'hC0, 1);

      sb(1, 5'b00000, 0);
      sb(0, 5'b10000, 0);
      chk("b_own4", int'(idx_b), 4);
      sb(0, 5'b10000, 1);
      chk("b_rls_vld", int'(vld_b), 0);
      sb(0, 5'b10001, 0);
      chk("b_wrap_idx", int'(idx_b), 0);
      repeat (3) begin
         sb(0, 5'b00000, 0);
         chk("b_hold_vld", int'(vld_b), 1);
         chk("b_hold_tout", int'(tout_b), 0);
      end
      sb(0, 5'b00000, 0);
      chk("b_to_vld", int'(vld_b), 0);
      chk("b_to_pulse", int'(tout_b), 1);
      sb(0, 5'b00000, 0);
      chk("b_to_once", int'(tout_b), 0);

      sb(0, 5'b00001, 0);
      chk("b_regrant", int'(vld_b), 1);
      repeat (3) sb(0, 5'b00000, 0);
      sb(0, 5'b00000, 1);
      chk("b_rlsto_vld", int'(vld_b), 0);
      chk("b_rlsto_tout", int'(tout_b), 0);

      // Second phase releases rarely so the 16-cycle timeout of instance A is exercised.
      for (int ph = 0; ph < 2; ph++) begin
         repeat (1500) begin
            bit       rst, la, lb;
            bit [7:0] ra;
            bit [4:0] rb;
            rst = ($urandom_range(99) == 0);
            ra  = 8'($urandom);
            rb  = 5'($urandom);
            la  = (ph == 0) ? ($urandom_range(3) == 0) : ($urandom_range(31) == 0);
            lb  = ($urandom_range(3) == 0);
            step(rst, ra, la, rb, lb);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
